// File: rtl/sme_host_tx.sv
// Host-side driver for the string-match engine: buffers a string and a pattern, serializes them, captures the result.
// Latency: first char the cycle after start is sampled; done the cycle after valid, or after TIMEOUT cycles in WAIT.
// Backpressure: none; start/load_en/load_clr are dropped while busy, and a buffer write when that buffer is full is dropped.
module sme_host_tx #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_clr,
   input  logic       load_en,
   input  logic       load_sel,
   input  logic [7:0] load_data,
   input  logic       start,
   input  logic       send_str,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       valid,
   input  logic       match,
   input  logic [4:0] match_index,
   output logic       busy,
   output logic       done,
   output logic       result_match,
   output logic [4:0] result_index,
   output logic       timeout_err
);

   localparam int SLW = $clog2(STR_MAX + 1);
   localparam int PLW = $clog2(PAT_MAX + 1);
   localparam int SIW = $clog2(STR_MAX);
   localparam int PIW = $clog2(PAT_MAX);
   localparam int CW  = $clog2(TIMEOUT);

   typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_str [STR_MAX];
   logic [7:0]       r_pat [PAT_MAX];
   logic [SLW-1:0]   r_str_len;
   logic [PLW-1:0]   r_pat_len;
   logic             r_sent_flag;
   logic [SLW-1:0]   r_idx, w_idx_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;

   logic             w_idle, w_start_ok, w_str_wr, w_pat_wr, w_sent_set;
   logic [7:0]       w_chardata;
   logic             w_isstring, w_ispattern, w_busy, w_done;
   logic             w_res_match, w_tmo;
   logic [4:0]       w_res_index;

   assign w_idle     = (r_state == IDLE);
   // A pattern-only send reuses the string the engine already holds, so it needs a prior string send.
   assign w_start_ok = w_idle && start && (r_pat_len != '0) &&
                       (send_str ? (r_str_len != '0) : r_sent_flag);
   // Clear beats append; appends to a full buffer are dropped.
   assign w_str_wr   = w_idle && load_en && !load_clr && !load_sel && (r_str_len != SLW'(STR_MAX));
   assign w_pat_wr   = w_idle && load_en && !load_clr &&  load_sel && (r_pat_len != PLW'(PAT_MAX));

   // Next-state and next-output logic; every output is then registered.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_chardata  = chardata;
      w_isstring  = isstring;
      w_ispattern = ispattern;
      w_busy      = busy;
      w_done      = 1'b0;
      w_res_match = result_match;
      w_res_index = result_index;
      w_tmo       = timeout_err;
      w_sent_set  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_busy    = 1'b1;
               w_tmo     = 1'b0;
               w_idx_nxt = SLW'(1);
               if (send_str) begin
                  w_state_nxt = SEND_STR;
                  w_chardata  = r_str[0];
                  w_isstring  = 1'b1;
               end else begin
                  w_state_nxt = SEND_PAT;
                  w_chardata  = r_pat[0];
                  w_ispattern = 1'b1;
               end
            end
         end
         SEND_STR: begin
            if (r_idx == r_str_len) begin
               // Last string char was on the wire; roll straight into the pattern.
               w_sent_set  = 1'b1;
               w_state_nxt = SEND_PAT;
               w_isstring  = 1'b0;
               w_ispattern = 1'b1;
               w_chardata  = r_pat[0];
               w_idx_nxt   = SLW'(1);
            end else begin
               w_chardata = r_str[r_idx[SIW-1:0]];
               w_idx_nxt  = r_idx + SLW'(1);
            end
         end
         SEND_PAT: begin
            if (r_idx == SLW'(r_pat_len)) begin
               w_state_nxt = WAIT;
               w_ispattern = 1'b0;
               w_chardata  = 8'd0;
               w_cnt_nxt   = '0;
            end else begin
               w_chardata = r_pat[r_idx[PIW-1:0]];
               w_idx_nxt  = r_idx + SLW'(1);
            end
         end
         WAIT: begin
            if (valid) begin
               w_res_match = match;
               w_res_index = match_index;
               w_done      = 1'b1;
               w_busy      = 1'b0;
               w_state_nxt = DONE;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_res_match = 1'b0;
               w_res_index = 5'd0;
               w_tmo       = 1'b1;
               w_done      = 1'b1;
               w_busy      = 1'b0;
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, sequencing counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         chardata     <= 8'd0;
         isstring     <= 1'b0;
         ispattern    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_match <= 1'b0;
         result_index <= 5'd0;
         timeout_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_cnt        <= w_cnt_nxt;
         chardata     <= w_chardata;
         isstring     <= w_isstring;
         ispattern    <= w_ispattern;
         busy         <= w_busy;
         done         <= w_done;
         result_match <= w_res_match;
         result_index <= w_res_index;
         timeout_err  <= w_tmo;
      end
   end

   // Buffer lengths and the string-already-sent flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_str_len   <= '0;
         r_pat_len   <= '0;
         r_sent_flag <= 1'b0;
      end else begin
         if (w_sent_set) r_sent_flag <= 1'b1;
         if (w_idle && load_clr) begin
            r_str_len <= '0;
            r_pat_len <= '0;
         end else begin
            if (w_str_wr) r_str_len <= r_str_len + SLW'(1);
            if (w_pat_wr) r_pat_len <= r_pat_len + PLW'(1);
         end
      end
   end

   // Character storage; contents are don't-care until loaded.
   always_ff @(posedge clk) begin
      if (w_str_wr) r_str[r_str_len[SIW-1:0]] <= load_data;
      if (w_pat_wr) r_pat[r_pat_len[PIW-1:0]] <= load_data;
   end

endmodule

// File: tb/tb_sme_host_tx.sv
// Directed bench for sme_host_tx: vector table of whole transactions plus hand sequences.
// Latency: observes the serialized stream cycle by cycle from the cycle after start.
// Backpressure: engine side is modelled by driving valid at a chosen WAIT cycle (or never).
module tb_sme_host_tx;

   logic       clk = 1'b0;
   logic       reset, load_clr, load_en, load_sel, start, send_str;
   logic [7:0] load_data;
   logic [7:0] chardata;
   logic       isstring, ispattern, valid, match;
   logic [4:0] match_index;
   logic       busy, done, result_match, timeout_err;
   logic [4:0] result_index;

   int tests = 0;
   int fails = 0;

   sme_host_tx #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .load_clr(load_clr), .load_en(load_en),
      .load_sel(load_sel), .load_data(load_data), .start(start), .send_str(send_str),
      .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .valid(valid), .match(match), .match_index(match_index),
      .busy(busy), .done(done), .result_match(result_match),
      .result_index(result_index), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit         snd;
      int         vdelay;   // WAIT cycle on which valid is driven; -1 = never
      bit         m;
      logic [4:0] mi;
      int         exp_s;
      int         exp_p;
      int         exp_w;
      bit         exp_m;
      logic [4:0] exp_i;
      bit         exp_tmo;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_bufs(input string s, input string p);
      load_clr = 1'b1;
      tick();
      load_clr = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
         load_en = 1'b1; load_sel = 1'b0; load_data = s[i];
         tick();
      end
      for (int i = 0; i < p.len(); i++) begin
         load_en = 1'b1; load_sel = 1'b1; load_data = p[i];
         tick();
      end
      load_en = 1'b0;
   endtask

   // Watch for ncyc cycles that neither busy nor done ever rises.
   task automatic check_idle(input string name, input int ncyc);
      int seen;
      seen = 0;
      for (int i = 0; i < ncyc; i++) begin
         if (busy || done) seen++;
         tick();
      end
      check(name, seen, 0);
   endtask

   task automatic run_txn(input string s, input string p, input vec_t v, input bit disturb);
      int sc, pc, wc, lastp, errs, both;
      bit got_done;
      sc = 0; pc = 0; wc = 0; lastp = 0; errs = 0; both = 0; got_done = 1'b0;
      start = 1'b1; send_str = v.snd;
      tick();
      start = 1'b0; send_str = 1'b0;
      check("busy_after_start", busy, 1);
      check("tmo_clear_on_start", timeout_err, 0);
      for (int cyc = 1; cyc < 300 && !got_done; cyc++) begin
         valid = 1'b0; match = 1'b0; match_index = 5'd0;
         start = 1'b0; load_en = 1'b0; load_clr = 1'b0;
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (isstring && ispattern) both++;
            if (!busy) errs++;
            if (isstring) begin
               if (sc >= s.len() || chardata != s[sc]) errs++;
               sc++;
               valid = 1'b1; match = ~v.m; match_index = ~v.mi;   // stale result must be ignored
            end else if (ispattern) begin
               if (pc >= p.len() || chardata != p[pc]) errs++;
               pc++;
               lastp = cyc;
               valid = 1'b1; match = ~v.m; match_index = ~v.mi;
            end else begin
               if (chardata != 8'd0) errs++;
               if (wc == v.vdelay) begin
                  valid = 1'b1; match = v.m; match_index = v.mi;
               end
               wc++;
            end
            if (disturb && cyc == 2) begin
               start = 1'b1; send_str = 1'b1;
               load_en = 1'b1; load_sel = 1'b0; load_data = "Z";
            end
            if (disturb && cyc == 3) begin
               start = 1'b1; load_clr = 1'b1;
            end
            tick();
         end
      end
      valid = 1'b0; start = 1'b0; load_en = 1'b0; load_clr = 1'b0; send_str = 1'b0;
      check("done_seen", got_done, 1);
      check("str_cycles", sc, v.exp_s);
      check("pat_cycles", pc, v.exp_p);
      check("wait_cycles", wc, v.exp_w);
      check("last_pat_cycle", lastp, v.exp_s + v.exp_p);
      check("stream_errors", errs, 0);
      check("str_pat_overlap", both, 0);
      check("busy_low_at_done", busy, 0);
      check("result_match", result_match, v.exp_m);
      check("result_index", result_index, v.exp_i);
      check("timeout_err", timeout_err, v.exp_tmo);
      tick();
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("result_hold", result_index, v.exp_i);
   endtask

   vec_t  vt [5];
   string vs [5];
   string vp [5];
   vec_t  vd;

   initial begin
      //            snd vdly m  mi     s   p  w   em ei    tmo
      vt[0] = '{1'b1,  0, 1'b1, 5'd4,   6, 2,  1, 1'b1, 5'd4,  1'b0};
      vt[1] = '{1'b0,  3, 1'b0, 5'd7,   0, 2,  4, 1'b0, 5'd7,  1'b0};
      vt[2] = '{1'b1,  5, 1'b1, 5'd31, 32, 8,  6, 1'b1, 5'd31, 1'b0};
      vt[3] = '{1'b1, -1, 1'b1, 5'd9,   2, 1, 64, 1'b0, 5'd0,  1'b1};
      vt[4] = '{1'b1,  1, 1'b1, 5'd0,   1, 1,  2, 1'b1, 5'd0,  1'b0};
      vs[0] = "abc de"; vp[0] = "de";
      vs[1] = "abc de"; vp[1] = "xy";
      vs[2] = "abcdefghijklmnopqrstuvwxyz0123456"; vp[2] = "ABCDEFGHI";
      vs[3] = "ab";     vp[3] = "c";
      vs[4] = "q";      vp[4] = "r";

      reset = 1'b1; load_clr = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_data = 8'd0;
      start = 1'b0; send_str = 1'b0; valid = 1'b0; match = 1'b0; match_index = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_chardata", chardata, 0);
      check("rst_flags", {isstring, ispattern}, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_results", {result_match, result_index, timeout_err}, 0);
      reset = 1'b0;
      tick();

      // Pattern-only start before any string has been sent.
      load_bufs("", "z");
      start = 1'b1; send_str = 1'b0;
      tick();
      start = 1'b0;
      check_idle("start_no_sent_flag", 4);

      // Clear wins over a same-cycle append, leaving pat_len at 0.
      load_clr = 1'b1; load_en = 1'b1; load_sel = 1'b1; load_data = "q";
      tick();
      load_clr = 1'b0; load_sel = 1'b0; load_data = "a";
      tick();
      load_en = 1'b0;
      start = 1'b1; send_str = 1'b1;
      tick();
      start = 1'b0; send_str = 1'b0;
      check_idle("start_pat_empty", 4);

      for (int i = 0; i < 5; i++) begin
         load_bufs(vs[i], vp[i]);
         run_txn(vs[i], vp[i], vt[i], 1'b0);
      end

      // Start/load/clear during SEND_STR are ignored; a repeat send shows identical buffers.
      vd = '{1'b1, 2, 1'b1, 5'd3, 6, 2, 3, 1'b1, 5'd3, 1'b0};
      load_bufs("abcdef", "gh");
      run_txn("abcdef", "gh", vd, 1'b1);
      check_idle("no_queued_start", 3);
      run_txn("abcdef", "gh", vd, 1'b0);

      // Reset in the middle of SEND_PAT.
      load_bufs("ab", "cdef");
      start = 1'b1; send_str = 1'b1;
      tick();
      start = 1'b0; send_str = 1'b0;
      tick();
      tick();
      check("pre_reset_in_pat", ispattern, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_chardata", chardata, 0);
      check("rst_mid_flags", {isstring, ispattern}, 0);
      check("rst_mid_busy_done", {busy, done}, 0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_idle", {busy, done, isstring, ispattern}, 0);
      load_bufs("", "x");
      start = 1'b1; send_str = 1'b0;
      tick();
      start = 1'b0;
      check_idle("start_after_rst_sent_clr", 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
